// File: rtl/mips_defs_pkg.sv
// Shared encodings for the execute-stage multiply / HI-LO unit.
// The FSM state, MFHI/MFLO select codes and ALU op code all live here.
package mips_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mul_state_t;

    localparam logic [1:0] HILO_MF_LO   = 2'b00;
    localparam logic [1:0] HILO_MF_HI   = 2'b01;
    localparam logic [1:0] HILO_MF_NONE = 2'b10;

    localparam logic [2:0] ALU_MULT = 3'b100;

endpackage

// File: rtl/mul_iter_core.sv
// Shift-add multiply datapath: one partial product per step, with sign fix-up
// applied combinationally on the finished magnitude product.
module mul_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               hassign,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               sign;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    always_comb begin
        a_mag  = (hassign && a[WIDTH-1]) ? -a : a;
        b_mag  = (hassign && b[WIDTH-1]) ? -b : b;
        addend = mplier[0] ? mcand : '0;
        // Carry out of the upper half becomes the new top bit after the shift.
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sign   <= 1'b0;
        end else if (load) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            sign   <= hassign & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            acc    <= {sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
        end
    end

    assign product = sign ? -acc : acc;

endmodule

// File: rtl/mult_hilo_unit.sv
// Iterative MULT/MULTU unit owning HI/LO; stalls the pipeline while the
// shift-add runs and serves MFHI/MFLO reads combinationally.
//
//   state | meaning
//   IDLE  | waiting for start; accept cycle asserts stall
//   BUSY  | WIDTH shift-add iterations, stall held
//   DONE  | stall released, HI/LO written at the closing edge
module mult_hilo_unit
    import mips_defs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hassign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       hilo_mf,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t         state;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic [2*WIDTH-1:0] product;

    assign accept = (state == ST_IDLE) && start && !flush;
    assign stall  = !flush && ((state == ST_BUSY) || accept);

    mul_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .step    (state == ST_BUSY),
        .hassign (hassign),
        .a       (a),
        .b       (b),
        .product (product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_BUSY;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    count <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is still high from the same MULT here, so it is not re-sampled.
                    {hi, lo} <= product;
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (hilo_mf)
            HILO_MF_LO: hilo_rdata = lo;
            HILO_MF_HI: hilo_rdata = hi;
            default:    hilo_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Scenario bench for mult_hilo_unit: expected products are queued at issue
// and popped when the multiply completes.
module tb_mult_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hassign;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  hilo_mf;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hilo_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] exp_q[$];

    mult_hilo_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hassign    (hassign),
        .a          (a),
        .b          (b),
        .hilo_mf    (hilo_mf),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .hilo_rdata (hilo_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sp;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            sp = sx * sy;
            return sp;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Drive a start in the current cycle (caller is already at a negedge).
    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y, input bit push);
        start   = 1'b1;
        hassign = s;
        a       = x;
        b       = y;
        if (push) exp_q.push_back(model(s, x, y));
    endtask

    // Count stall cycles until the DONE cycle; returns at negedge+1 of DONE.
    task automatic wait_done(output int stalls);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) return;
            stalls++;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_done: stall never dropped within 100 cycles");
    endtask

    // From the DONE cycle: check busy, then read back the result the cycle after.
    task automatic finish_mult(input string name);
        logic [63:0] e;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_in_done: got %b want 1", name, busy);
        end
        @(negedge clk);
        start   = 1'b0;
        hilo_mf = 2'b01;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard: no expected result queued", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (hilo_rdata !== e[63:32]) begin
            failures++;
            $display("FAIL %s mfhi_after_done: got %h want %h", name, hilo_rdata, e[63:32]);
        end
        checks++;
        if (hi !== e[63:32] || lo !== e[31:0]) begin
            failures++;
            $display("FAIL %s hilo: got %h_%h want %h_%h", name, hi, lo, e[63:32], e[31:0]);
        end
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after: stall=%b busy=%b want 0 0", name, stall, busy);
        end
        hilo_mf = 2'b00;
        #1;
        checks++;
        if (hilo_rdata !== e[31:0]) begin
            failures++;
            $display("FAIL %s mflo: got %h want %h", name, hilo_rdata, e[31:0]);
        end
        hilo_mf = 2'b10;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hassign = 1'b0; flush = 1'b0;
        a = '0; b = '0; hilo_mf = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (hilo_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mflo: got %h want 0", hilo_rdata);
        end
        hilo_mf = 2'b01;
        #1;
        checks++;
        if (hilo_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mfhi: got %h want 0", hilo_rdata);
        end
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: stall=%b busy=%b want 0 0", stall, busy);
        end
        hilo_mf = 2'b10;
    endtask

    task automatic test_multu_max();
        int n;
        @(negedge clk);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(n);
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL multu_stall_cycles: got %0d want 33", n);
        end
        finish_mult("multu_max");
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", hi, lo);
        end
    endtask

    task automatic test_mult_signed();
        int n;
        logic [31:0] va[4] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFF9, 32'h0001_2345};
        logic [31:0] vb[4] = '{32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFF7, 32'hFFFE_0001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue(1'b1, va[i], vb[i], 1'b1);
            wait_done(n);
            checks++;
            if (n != 33) begin
                failures++;
                $display("FAIL mult_stall_cycles[%0d]: got %0d want 33", i, n);
            end
            finish_mult($sformatf("mult[%0d]", i));
            if (i == 0) begin
                checks++;
                if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
                    failures++;
                    $display("FAIL mult_neg2x3: got %h_%h want ffffffff_fffffffa", hi, lo);
                end
            end else if (i == 1) begin
                checks++;
                if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
                    failures++;
                    $display("FAIL mult_minint_sq: got %h_%h want 40000000_00000000", hi, lo);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int t0;
        int t1;
        logic [63:0] e;
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0009, 1'b1);
        t0 = cyc;
        wait_done(n);
        checks++;
        if (n != 33 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: stalls=%0d busy=%b want 33 1", n, busy);
        end
        @(negedge clk);
        issue(1'b0, 32'h0001_0000, 32'h0001_0001, 1'b1);
        #1;
        t1 = cyc;
        checks++;
        if (t1 - t0 != 34 || stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: gap=%0d stall=%b want 34 1", t1 - t0, stall);
        end
        e = exp_q.pop_front();
        checks++;
        if (hi !== e[63:32] || lo !== e[31:0]) begin
            failures++;
            $display("FAIL b2b_first_hilo: got %h_%h want %h_%h", hi, lo, e[63:32], e[31:0]);
        end
        wait_done(n);
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL b2b_second_stalls: got %0d want 33", n);
        end
        finish_mult("b2b_second");
    endtask

    task automatic test_flush();
        int n;
        @(negedge clk);
        issue(1'b0, 32'h2468_ACF0, 32'h8000_0000, 1'b1);
        wait_done(n);
        finish_mult("flush_setup");
        @(negedge clk);
        issue(1'b1, 32'd7, 32'd9, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_cycle: stall=%b busy=%b want 0 1", stall, busy);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h0) begin
            failures++;
            $display("FAIL flush_after: stall=%b busy=%b hi=%h lo=%h want 0 0 12345678 00000000",
                     stall, busy, hi, lo);
        end
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_idle_stall: got %b want 0", stall);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_idle_busy: busy=%b stall=%b want 0 0", busy, stall);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        issue(1'b1, 32'd7, 32'd9, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || stall !== 1'b1 || hi !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rst_mid_pre: busy=%b stall=%b hi=%h want 1 1 12345678", busy, stall, hi);
        end
        rst   = 1'b1;
        start = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || stall !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: hi=%h lo=%h stall=%b busy=%b want 0 0 0 0", hi, lo, stall, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_after: busy=%b hi=%h want 0 0", busy, hi);
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Execute-stage consumer of the ALU decoder's multiply controls (hilo_en, hassign, hilo_mf).
- Performs 32x32 MULT/MULTU as an iterative shift-add over multiple cycles and owns the architectural HI/LO registers.
- Stalls the pipeline while a multiply is in flight.
- Serves MFHI/MFLO reads of HI/LO back to the EX result mux.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits and is split into HI (upper) and LO (lower).
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
clk  input  1  pipeline clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  hilo_en from the decoder, qualified by a valid EX instruction.
hassign  input  1  1 = signed MULT, 0 = MULTU; sampled only with an accepted start.
a  input  WIDTH  rs operand.
b  input  WIDTH  rt operand.
hilo_mf  input  2  read select: 00 = LO, 01 = HI, 10 = none.
flush  input  1  EX flush; aborts any multiply in flight.
stall  output  1  hold IF/ID/EX; combinational.
busy  output  1  registered; high in BUSY and DONE.
hilo_rdata  output  WIDTH  MFHI/MFLO read data; combinational.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
Reset:
- State -> IDLE; hi, lo, counter, accumulator and operand registers -> 0; busy = 0; stall = 0.

FSM (IDLE, BUSY, DONE):
- IDLE, start=1, flush=0:
  - stall=1 this cycle.
  - Capture |a|, |b| (magnitudes when hassign=1, raw values otherwise).
  - Capture sign = hassign & (a[31] ^ b[31]).
  - Clear accumulator; count <= 0; go to BUSY.
- BUSY:
  - stall=1.
  - Each cycle: if multiplier LSB=1, add the multiplicand into the upper half of the accumulator; shift right one bit. Carry-out is preserved.
  - count increments. When count == WIDTH-1, go to DONE.
  - Exactly WIDTH (32) BUSY cycles.
- DONE:
  - stall=0; the pipeline advances the MULT out of EX at this edge.
  - At the edge: {hi,lo} <= sign ? -product : product (two's complement, 64-bit). Go to IDLE.
  - start is ignored in DONE, because it is still high from the same instruction.
- Latency:
  - 33 stall cycles (1 IDLE-accept + 32 BUSY).
  - HI/LO are visible from the cycle after DONE.
  - Total occupancy is 34 cycles.

Read path:
- hilo_rdata = lo when hilo_mf=00, hi when 01, 0 when 10; 11 reads as 0.
- A read in the cycle right after DONE sees the new values; no forwarding is needed.
- start and a read never coincide, since they are different instructions.

Boundary conditions:
- flush in BUSY or DONE: return to IDLE next edge; hi/lo unchanged; stall=0 in the flush cycle.
- flush and start together in IDLE: start is ignored.
- rst asserted mid-multiply: immediate return to IDLE; hi/lo cleared.
- Signed boundary: 0x80000000 has magnitude 0x80000000 as unsigned. The 64-bit accumulator must not overflow: max product (2^32-1)^2 fits in 64 bits.
- hi and lo are written only in DONE. No other path writes them (MTHI/MTLO are out of scope).

Decomposition:
- Shared package mips_defs_pkg holds:
  - FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10).
  - hilo_mf codes (HILO_MF_LO=2'b00, HILO_MF_HI=2'b01, HILO_MF_NONE=2'b10).
  - ALU_MULT=3'b100.
- One sub-module, mul_iter_core:
  - Holds the shift-add datapath: multiplicand/multiplier/accumulator registers, the iteration step, and final conditional negation.
  - Controlled by the FSM through load/step enables.
- mult_hilo_unit keeps the FSM, counter, stall logic and the HI/LO registers.

Test Plan:
- Reset, then idle read: hilo_mf=00 and 01 -> hilo_rdata=0; stall=0; busy=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - stall high exactly 33 cycles, low in DONE.
  - Afterwards hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- MFHI in the cycle right after DONE -> hilo_rdata=new hi.
- Back-to-back MULTs -> second accepted only after returning to IDLE; 34 cycles apart.
- Prior hi=0x12345678; start MULT 7*9, assert flush at BUSY cycle 10:
  - Next cycle: IDLE, stall=0, hi still 0x12345678.
- Separately, assert rst at BUSY cycle 5 -> immediate IDLE, hi=lo=0, stall=0.
